weight_load_ctrl: RTL and testbench

Sequencer that fills a bank of NUM_LANES weight_reg instances from one valid/ready weight stream.
Each accepted weight is driven onto a shared weight bus with a one-hot per-lane reload strobe, in ascending lane order starting at lane 0.
Busy/done tell the vector-multiplier compute path when weights are stable.
Sits between the weight source (host/memory) and the weight_reg array.

---
 rtl/weight_load_ctrl.sv | 169 ++++++++++++++++
 tb/tb_weight_load_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/weight_load_ctrl.sv
// ---------------------------------------------------------------------------
// weight_load_ctrl
//   Fills a bank of NUM_LANES weight_reg lanes from a single valid/ready
//   weight stream. Each accepted beat is presented on the shared weight bus
//   one cycle later together with a one-hot reload strobe. Lanes are filled in
//   ascending order starting at lane 0.
//
// Ports
//   clk           : clock, rising edge
//   rst           : asynchronous active-high reset
//   start         : single-cycle request to begin a load sequence
//   load_count    : number of lanes to load, sampled when start is accepted
//   abort         : cancel the sequence in progress
//   w_valid       : weight stream valid
//   w_data        : weight stream data (signed)
//   w_ready       : weight stream ready (combinational)
//   weight_bus    : shared weight_in for all lanes (registered)
//   weight_reload : one-hot per-lane reload strobes (registered)
//   busy          : sequence in progress (LOAD / DRAIN)
//   done          : one-cycle pulse on normal completion
//   err           : one-cycle pulse when start carries an illegal load_count
// ---------------------------------------------------------------------------
module weight_load_ctrl #(
    parameter  int NUM_LANES = 4,
    parameter  int WEIGHT_BW = 8,
    localparam int CNT_BW    = $clog2(NUM_LANES) + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [CNT_BW-1:0]           load_count,
    input  logic                        abort,
    input  logic                        w_valid,
    input  logic signed [WEIGHT_BW-1:0] w_data,
    output logic                        w_ready,
    output logic signed [WEIGHT_BW-1:0] weight_bus,
    output logic [NUM_LANES-1:0]        weight_reload,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                       state_r;
    state_t                       state_next_s;
    logic [CNT_BW-1:0]            lane_cnt_r;
    logic [CNT_BW-1:0]            count_r;
    logic signed [WEIGHT_BW-1:0]  weight_bus_r;
    logic [NUM_LANES-1:0]         weight_reload_r;
    logic                         busy_r;
    logic                         done_r;
    logic                         err_r;

    logic                         accept_s;
    logic                         last_beat_s;
    logic                         count_ok_s;
    logic                         start_idle_s;

    // One-hot strobe for a lane index.
    function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [CNT_BW-1:0] idx);
        lane_onehot = {{(NUM_LANES-1){1'b0}}, 1'b1} << idx;
    endfunction

    assign w_ready       = (state_r == ST_LOAD) && !abort;
    assign accept_s      = w_valid && w_ready;
    assign start_idle_s  = (state_r == ST_IDLE) && start;
    assign count_ok_s    = (load_count != {CNT_BW{1'b0}}) &&
                           (load_count <= CNT_BW'(NUM_LANES));
    // count_r is at least 1 whenever LOAD is active, so the subtraction cannot wrap.
    assign last_beat_s   = (lane_cnt_r == (count_r - {{(CNT_BW-1){1'b0}}, 1'b1}));

    assign weight_bus    = weight_bus_r;
    assign weight_reload = weight_reload_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign err           = err_r;

    // Next-state decode for the load sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start && count_ok_s) begin
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_next_s = ST_IDLE;
                end else if (accept_s && last_beat_s) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_DRAIN: begin
                if (abort) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Latched lane count and lane counter; counter advances once per accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r    <= {CNT_BW{1'b0}};
            lane_cnt_r <= {CNT_BW{1'b0}};
        end else if (start_idle_s && count_ok_s) begin
            count_r    <= load_count;
            lane_cnt_r <= {CNT_BW{1'b0}};
        end else if (accept_s) begin
            lane_cnt_r <= lane_cnt_r + {{(CNT_BW-1){1'b0}}, 1'b1};
        end
    end

    // Weight bus and reload strobe: a beat accepted this cycle is driven next cycle;
    // the bus holds its last value through bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            weight_bus_r    <= {WEIGHT_BW{1'b0}};
            weight_reload_r <= {NUM_LANES{1'b0}};
        end else if (accept_s) begin
            weight_bus_r    <= w_data;
            weight_reload_r <= lane_onehot(lane_cnt_r);
        end else begin
            weight_reload_r <= {NUM_LANES{1'b0}};
        end
    end

    // Registered status flags derived from the upcoming state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            busy_r <= (state_next_s == ST_LOAD) || (state_next_s == ST_DRAIN);
            done_r <= (state_next_s == ST_DONE);
            err_r  <= start_idle_s && !count_ok_s;
        end
    end

endmodule

// File: tb/tb_weight_load_ctrl.sv
module tb_weight_load_ctrl;

    localparam int NL = 4;
    localparam int WB = 8;
    localparam int CB = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [CB-1:0]        load_count;
    logic                 abort;
    logic                 w_valid;
    logic signed [WB-1:0] w_data;
    logic                 w_ready;
    logic signed [WB-1:0] weight_bus;
    logic [NL-1:0]        weight_reload;
    logic                 busy;
    logic                 done;
    logic                 err;

    weight_load_ctrl #(.NUM_LANES(NL), .WEIGHT_BW(WB)) dut (
        .clk(clk), .rst(rst), .start(start), .load_count(load_count),
        .abort(abort), .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
        .weight_bus(weight_bus), .weight_reload(weight_reload),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: sequence described as "lanes loaded so far / target",
    // plus the strobe, done and err events scheduled for the current cycle.
    bit                   m_loading;
    bit                   m_drain;
    bit                   m_done;
    bit                   m_err;
    int                   m_target;
    int                   m_next_lane;
    int                   m_rl;       // lane strobed this cycle, -1 for none
    logic signed [WB-1:0] m_bus;

    // Weight-register bank as the lanes should see it, and as the DUT drives it.
    logic signed [WB-1:0] exp_bank [NL];
    logic signed [WB-1:0] act_bank [NL];

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    endtask

    task automatic model_reset();
        m_loading = 1'b0; m_drain = 1'b0; m_done = 1'b0; m_err = 1'b0;
        m_target = 0; m_next_lane = 0; m_rl = -1; m_bus = '0;
    endtask

    // One clock cycle: drive inputs, check every output, advance model.
    task automatic step(input bit st, input int cnt, input bit ab, input bit vl,
                        input logic signed [WB-1:0] d);
        bit accept;
        int n_rl;
        bit n_done, n_err, n_loading, n_drain;
        start = st; load_count = CB'(cnt); abort = ab; w_valid = vl; w_data = d;
        #2;
        check_val("w_ready", 32'(w_ready), 32'(m_loading && !ab));
        check_val("weight_reload", 32'(weight_reload), (m_rl >= 0) ? (32'd1 << m_rl) : 32'd0);
        check_val("weight_bus", 32'(weight_bus), 32'(m_bus));
        check_val("busy", 32'(busy), 32'(m_loading || m_drain));
        check_val("done", 32'(done), 32'(m_done));
        check_val("err", 32'(err), 32'(m_err));
        if (m_done) begin
            for (int i = 0; i < NL; i++) check_val("bank", 32'(act_bank[i]), 32'(exp_bank[i]));
        end
        // Lanes capture the bus at the edge ending the strobe cycle.
        if (m_rl >= 0) exp_bank[m_rl] = m_bus;
        for (int i = 0; i < NL; i++) if (weight_reload[i]) act_bank[i] = weight_bus;

        accept = m_loading && !ab && vl;
        n_rl = -1; n_done = 1'b0; n_err = 1'b0; n_loading = m_loading; n_drain = 1'b0;
        if (accept) begin
            n_rl = m_next_lane;
            m_bus = d;
            m_next_lane++;
        end
        if (m_loading) begin
            if (ab) n_loading = 1'b0;
            else if (accept && m_next_lane == m_target) begin
                n_loading = 1'b0; n_drain = 1'b1;
            end
        end else if (m_drain) begin
            n_done = !ab;
        end else if (!m_done && st) begin
            if (cnt >= 1 && cnt <= NL) begin
                n_loading = 1'b1; m_target = cnt; m_next_lane = 0;
            end else begin
                n_err = 1'b1;
            end
        end
        m_loading = n_loading; m_drain = n_drain; m_done = n_done; m_err = n_err; m_rl = n_rl;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must clear at once.
    task automatic do_reset();
        start = 1'b0; abort = 1'b0; w_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_val("rst_reload", 32'(weight_reload), 32'd0);
        check_val("rst_bus", 32'(weight_bus), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_err", 32'(err), 32'd0);
        check_val("rst_ready", 32'(w_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0, 8'sd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; w_valid = 1'b0;
        load_count = '0; w_data = '0;
        for (int i = 0; i < NL; i++) begin exp_bank[i] = '0; act_bank[i] = '0; end
        model_reset();
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        idle(2);

        // Full back-to-back load.
        step(1'b1, 4, 1'b0, 1'b0, 8'sd0);
        step(1'b0, 0, 1'b0, 1'b1, 8'sd3);
        step(1'b0, 0, 1'b0, 1'b1, -8'sd5);
        step(1'b0, 0, 1'b0, 1'b1, 8'sd127);
        step(1'b0, 0, 1'b0, 1'b1, -8'sd128);
        idle(3);

        // Two bubbles between beats 2 and 3.
        step(1'b1, 4, 1'b0, 1'b0, 8'sd0);
        step(1'b0, 0, 1'b0, 1'b1, 8'sd3);
        step(1'b0, 0, 1'b0, 1'b1, -8'sd5);
        step(1'b0, 0, 1'b0, 1'b0, 8'sd77);
        step(1'b0, 0, 1'b0, 1'b0, 8'sd77);
        step(1'b0, 0, 1'b0, 1'b1, 8'sd127);
        step(1'b0, 0, 1'b0, 1'b1, -8'sd128);
        idle(3);

        // Partial load of two lanes; a third offered beat must not be taken.
        step(1'b1, 2, 1'b0, 1'b0, 8'sd0);
        step(1'b0, 0, 1'b0, 1'b1, 8'sd11);
        step(1'b0, 0, 1'b0, 1'b1, 8'sd22);
        step(1'b0, 0, 1'b0, 1'b1, 8'sd33);
        idle(3);

        // Illegal counts.
        step(1'b1, 0, 1'b0, 1'b0, 8'sd0);
        idle(1);
        step(1'b1, 5, 1'b0, 1'b0, 8'sd0);
        idle(2);

        // Abort on the cycle of beat 3.
        step(1'b1, 4, 1'b0, 1'b0, 8'sd0);
        step(1'b0, 0, 1'b0, 1'b1, 8'sd41);
        step(1'b0, 0, 1'b0, 1'b1, 8'sd42);
        step(1'b0, 0, 1'b1, 1'b1, 8'sd43);
        idle(3);

        // Start while busy is ignored.
        step(1'b1, 4, 1'b0, 1'b0, 8'sd0);
        step(1'b0, 0, 1'b0, 1'b1, 8'sd51);
        step(1'b1, 1, 1'b0, 1'b1, 8'sd52);
        step(1'b0, 0, 1'b0, 1'b1, 8'sd53);
        step(1'b0, 0, 1'b0, 1'b1, 8'sd54);
        idle(3);

        // Reset after two of four beats, then a fresh sequence from lane 0.
        step(1'b1, 4, 1'b0, 1'b0, 8'sd0);
        step(1'b0, 0, 1'b0, 1'b1, 8'sd61);
        step(1'b0, 0, 1'b0, 1'b1, 8'sd62);
        do_reset();
        idle(1);
        step(1'b1, 4, 1'b0, 1'b0, 8'sd0);
        for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b0, 1'b1, WB'(70 + i));
        idle(3);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) == 0, int'($urandom_range(0, 5)),
                     $urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0,
                     WB'($urandom));
            end
        end
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
